ts_cc_monitor: RTL and testbench

TS_CC_MONITOR -- requirements
Module: ts_cc_monitor

---
 rtl/ts_cc_monitor_if.sv | 26 ++
 rtl/ts_cc_monitor.sv | 247 ++++++++++++++++++++++++
 tb/tb_ts_cc_monitor.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ts_cc_monitor_if.sv
// Bus bundle for ts_cc_monitor: byte stream in, PID configuration, clear,
// and the per-slot continuity status returned by the monitor.
interface ts_cc_monitor_if #(
    parameter int NUM_PID   = 4,
    parameter int ERR_CNT_W = 16
);
    logic [7:0]                   data_in;
    logic                         data_in_en;
    logic [13*NUM_PID-1:0]        pid_cfg;
    logic [NUM_PID-1:0]           pid_en;
    logic                         clr;
    logic [NUM_PID-1:0]           cc_err_flag;
    logic [ERR_CNT_W*NUM_PID-1:0] cc_err_cnt;
    logic                         sync_err;
    logic                         ts_strobe;

    modport master (
        output data_in, data_in_en, pid_cfg, pid_en, clr,
        input  cc_err_flag, cc_err_cnt, sync_err, ts_strobe
    );

    modport slave (
        input  data_in, data_in_en, pid_cfg, pid_en, clr,
        output cc_err_flag, cc_err_cnt, sync_err, ts_strobe
    );
endinterface

// File: rtl/ts_cc_monitor.sv
// MPEG-TS continuity-counter monitor with NUM_PID independent PID slots.
// Define TS_CC_DUP_ALLOW_EN to accept one duplicate CC per slot without error.
module ts_cc_monitor #(
    parameter int NUM_PID   = 4,
    parameter int HDR_LEN   = 6,
    parameter int ERR_CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    ts_cc_monitor_if.slave bus
);

    localparam logic [5:0] HDR_LAST = 6'(HDR_LEN - 1);
    localparam logic [7:0] TS_LAST  = 8'd187;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_TS_HEAD,
        S_TS_BODY,
        S_DROP
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] hdr_cnt_q, hdr_cnt_d;
    logic [7:0] ts_idx_q, ts_idx_d;
    logic [4:0] pid_hi_q, pid_hi_d;
    logic [7:0] pid_lo_q, pid_lo_d;
    logic       wait_low_q, wait_low_d;
    logic       sync_err_q, sync_err_d;
    logic       ts_strobe_q;
    logic       ts_eval;

    // Byte framing: header skip, then 188-byte packets back to back.
    always_comb begin
        state_d    = state_q;
        hdr_cnt_d  = hdr_cnt_q;
        ts_idx_d   = ts_idx_q;
        pid_hi_d   = pid_hi_q;
        pid_lo_d   = pid_lo_q;
        wait_low_d = wait_low_q;
        sync_err_d = 1'b0;
        ts_eval    = 1'b0;
        if (!bus.data_in_en) begin
            state_d    = S_IDLE;
            hdr_cnt_d  = '0;
            ts_idx_d   = '0;
            wait_low_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (!wait_low_q) begin
                        if (HDR_LAST == 6'd0) begin
                            state_d   = S_TS_HEAD;
                            hdr_cnt_d = '0;
                        end else begin
                            state_d   = S_HDR;
                            hdr_cnt_d = 6'd1;
                        end
                        ts_idx_d = '0;
                    end
                end
                S_HDR: begin
                    if (hdr_cnt_q == HDR_LAST) begin
                        state_d   = S_TS_HEAD;
                        hdr_cnt_d = '0;
                        ts_idx_d  = '0;
                    end else begin
                        hdr_cnt_d = hdr_cnt_q + 6'd1;
                    end
                end
                S_TS_HEAD: begin
                    unique case (ts_idx_q[1:0])
                        2'd0: begin
                            if (bus.data_in != 8'h47) begin
                                sync_err_d = 1'b1;
                                state_d    = S_DROP;
                                ts_idx_d   = '0;
                            end else begin
                                ts_idx_d = 8'd1;
                            end
                        end
                        2'd1: begin
                            pid_hi_d = bus.data_in[4:0];
                            ts_idx_d = 8'd2;
                        end
                        2'd2: begin
                            pid_lo_d = bus.data_in;
                            ts_idx_d = 8'd3;
                        end
                        default: begin
                            ts_eval  = 1'b1;
                            state_d  = S_TS_BODY;
                            ts_idx_d = 8'd4;
                        end
                    endcase
                end
                S_TS_BODY: begin
                    if (ts_idx_q == TS_LAST) begin
                        state_d  = S_TS_HEAD;
                        ts_idx_d = '0;
                    end else begin
                        ts_idx_d = ts_idx_q + 8'd1;
                    end
                end
                S_DROP: begin
                    state_d = S_DROP;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // A reset mid-burst must not resynchronise onto the tail of that burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hdr_cnt_q   <= '0;
            ts_idx_q    <= '0;
            wait_low_q  <= 1'b1;
            sync_err_q  <= 1'b0;
            ts_strobe_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_cnt_q   <= hdr_cnt_d;
            ts_idx_q    <= ts_idx_d;
            wait_low_q  <= wait_low_d;
            sync_err_q  <= sync_err_d;
            ts_strobe_q <= ts_eval;
        end
    end

    always_ff @(posedge clk) begin
        pid_hi_q <= pid_hi_d;
        pid_lo_q <= pid_lo_d;
    end

    logic [12:0]                 pid_w;
    logic [3:0]                  cc_w;
    logic [12:0]                 cfg_k;
    logic                        err_k;
    logic [13*NUM_PID-1:0]       pid_cfg_q;
    logic [NUM_PID-1:0]          flag_q, flag_d;
    logic [NUM_PID-1:0]          valid_q, valid_d;
    logic [3:0]                  prev_q [NUM_PID];
    logic [3:0]                  prev_d [NUM_PID];
    logic [ERR_CNT_W-1:0]        cnt_q  [NUM_PID];
    logic [ERR_CNT_W-1:0]        cnt_d  [NUM_PID];
`ifdef TS_CC_DUP_ALLOW_EN
    logic [NUM_PID-1:0]          dup_q, dup_d;
`endif

    assign pid_w = {pid_hi_q, pid_lo_q};
    assign cc_w  = bus.data_in[3:0];

    // Per-slot continuity check, evaluated in the cycle carrying byte 3.
    always_comb begin
        flag_d  = flag_q;
        valid_d = valid_q;
        prev_d  = prev_q;
        cnt_d   = cnt_q;
        cfg_k   = '0;
        err_k   = 1'b0;
`ifdef TS_CC_DUP_ALLOW_EN
        dup_d   = dup_q;
`endif
        for (int k = 0; k < NUM_PID; k++) begin
            cfg_k = bus.pid_cfg[13*k +: 13];
            err_k = 1'b0;
            if (ts_eval && bus.pid_en[k] && (pid_w != 13'h1FFF) &&
                (pid_w == cfg_k) && bus.data_in[4]) begin
                prev_d[k]  = cc_w;
                valid_d[k] = 1'b1;
                if (!valid_q[k] || (cc_w == prev_q[k] + 4'd1)) begin
`ifdef TS_CC_DUP_ALLOW_EN
                    dup_d[k] = 1'b0;
                end else if ((cc_w == prev_q[k]) && !dup_q[k]) begin
                    dup_d[k] = 1'b1;
                end else begin
                    err_k    = 1'b1;
                    dup_d[k] = (cc_w == prev_q[k]);
                end
`else
                end else begin
                    err_k = 1'b1;
                end
`endif
            end
            if (err_k) begin
                flag_d[k] = 1'b1;
                if (cnt_q[k] != {ERR_CNT_W{1'b1}}) begin
                    cnt_d[k] = cnt_q[k] + ERR_CNT_W'(1);
                end
            end
            if (!bus.pid_en[k] || (cfg_k != pid_cfg_q[13*k +: 13])) begin
                valid_d[k] = 1'b0;
`ifdef TS_CC_DUP_ALLOW_EN
                dup_d[k]   = 1'b0;
`endif
            end
            if (bus.clr) begin
                flag_d[k]  = 1'b0;
                valid_d[k] = 1'b0;
                cnt_d[k]   = '0;
`ifdef TS_CC_DUP_ALLOW_EN
                dup_d[k]   = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_q  <= '0;
            valid_q <= '0;
            for (int k = 0; k < NUM_PID; k++) begin
                cnt_q[k] <= '0;
            end
`ifdef TS_CC_DUP_ALLOW_EN
            dup_q   <= '0;
`endif
        end else begin
            flag_q  <= flag_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
`ifdef TS_CC_DUP_ALLOW_EN
            dup_q   <= dup_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        prev_q    <= prev_d;
        pid_cfg_q <= bus.pid_cfg;
    end

    assign bus.cc_err_flag = flag_q;
    assign bus.sync_err    = sync_err_q;
    assign bus.ts_strobe   = ts_strobe_q;

    for (genvar g = 0; g < NUM_PID; g++) begin : g_cnt_out
        assign bus.cc_err_cnt[ERR_CNT_W*g +: ERR_CNT_W] = cnt_q[g];
    end

endmodule

// File: tb/tb_ts_cc_monitor.sv
// Directed bench for ts_cc_monitor: framing, CC wrap/error/duplicate, sync loss,
// clear priority, counter saturation, shared PIDs, AFC handling and reset.
module tb_ts_cc_monitor;

    localparam int NP = 4;
    localparam int HL = 6;
    localparam int EW = 4;
`ifdef TS_CC_DUP_ALLOW_EN
    localparam bit DUP = 1'b1;
`else
    localparam bit DUP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   strobe_cnt = 0;
    int   sync_cnt   = 0;
    int   base_s, base_y;

    always #5 clk = ~clk;

    ts_cc_monitor_if #(.NUM_PID(NP), .ERR_CNT_W(EW)) bus ();

    ts_cc_monitor #(.NUM_PID(NP), .HDR_LEN(HL), .ERR_CNT_W(EW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(negedge clk) begin
        if (bus.ts_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
        if (bus.sync_err === 1'b1) sync_cnt <= sync_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [EW-1:0] cnt_of(input int k);
        return bus.cc_err_cnt[EW*k +: EW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.data_in    = b;
        bus.data_in_en = 1'b1;
        tick();
    endtask

    task automatic gap(input int n);
        bus.data_in_en = 1'b0;
        bus.data_in    = 8'h00;
        repeat (n) tick();
    endtask

    task automatic send_hdr();
        for (int i = 0; i < HL; i++) send_byte(8'hA5);
    endtask

    task automatic send_head(input logic [7:0] b0, input logic [12:0] pid,
                             input logic [1:0] afc, input logic [3:0] cc);
        send_byte(b0);
        send_byte({3'b010, pid[12:8]});
        send_byte(pid[7:0]);
        send_byte({2'b00, afc, cc});
    endtask

    task automatic send_ts(input logic [7:0] b0, input logic [12:0] pid,
                           input logic [1:0] afc, input logic [3:0] cc);
        send_head(b0, pid, afc, cc);
        for (int i = 0; i < 184; i++) send_byte(8'hFF);
    endtask

    // One short burst: header, TS header, then enable drops.
    task automatic packet(input logic [12:0] pid, input logic [1:0] afc, input logic [3:0] cc);
        send_hdr();
        send_head(8'h47, pid, afc, cc);
        gap(1);
    endtask

    task automatic pulse_clr();
        bus.clr = 1'b1;
        gap(1);
        bus.clr = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        bus.data_in    = 8'h00;
        bus.data_in_en = 1'b0;
        bus.clr        = 1'b0;
        bus.pid_cfg    = '0;
        bus.pid_cfg[12:0] = 13'h1386;
        bus.pid_en     = 4'b0001;
        repeat (3) tick();
        rst = 1'b0;
        gap(1);

        check("rst_flag", 64'(bus.cc_err_flag), 64'h0);
        check("rst_cnt", 64'(bus.cc_err_cnt), 64'h0);
        check("rst_sync", 64'(bus.sync_err), 64'h0);
        check("rst_strobe", 64'(bus.ts_strobe), 64'h0);

        // Seven back-to-back packets, CC 0..6.
        base_s = strobe_cnt;
        send_hdr();
        for (int i = 0; i < 7; i++) send_ts(8'h47, 13'h1386, 2'b01, 4'(i));
        gap(2);
        check("seq7_flag", 64'(bus.cc_err_flag[0]), 64'h0);
        check("seq7_cnt", 64'(cnt_of(0)), 64'h0);
        check("seq7_strobes", 64'(strobe_cnt - base_s), 64'd7);

        // CC wrap 14,15,0,1 is legal.
        pulse_clr();
        packet(13'h1386, 2'b01, 4'd14);
        packet(13'h1386, 2'b01, 4'd15);
        packet(13'h1386, 2'b01, 4'd0);
        packet(13'h1386, 2'b01, 4'd1);
        check("wrap_flag", 64'(bus.cc_err_flag[0]), 64'h0);
        check("wrap_cnt", 64'(cnt_of(0)), 64'h0);

        // CC 3 then 5: error visible one edge after byte 3.
        pulse_clr();
        packet(13'h1386, 2'b01, 4'd3);
        send_hdr();
        send_byte(8'h47);
        send_byte({3'b010, 5'h13});
        send_byte(8'h86);
        check("gap_flag_before", 64'(bus.cc_err_flag[0]), 64'h0);
        send_byte({4'b0001, 4'd5});
        check("gap_flag", 64'(bus.cc_err_flag[0]), 64'h1);
        check("gap_cnt", 64'(cnt_of(0)), 64'h1);
        check("gap_strobe_hi", 64'(bus.ts_strobe), 64'h1);
        gap(1);
        check("gap_strobe_lo", 64'(bus.ts_strobe), 64'h0);

        // Duplicate CC handling.
        pulse_clr();
        packet(13'h1386, 2'b01, 4'd4);
        packet(13'h1386, 2'b01, 4'd4);
        check("dup2_cnt", 64'(cnt_of(0)), DUP ? 64'd0 : 64'd1);
        packet(13'h1386, 2'b01, 4'd4);
        check("dup3_cnt", 64'(cnt_of(0)), DUP ? 64'd1 : 64'd2);
        packet(13'h1386, 2'b01, 4'd5);
        packet(13'h1386, 2'b01, 4'd5);
        check("dup_rearm_cnt", 64'(cnt_of(0)), DUP ? 64'd1 : 64'd3);

        // Sync loss in the second packet drops the rest of the burst.
        pulse_clr();
        base_s = strobe_cnt;
        base_y = sync_cnt;
        send_hdr();
        send_ts(8'h47, 13'h1386, 2'b01, 4'd0);
        send_byte(8'h48);
        check("sync_pulse", 64'(bus.sync_err), 64'h1);
        send_byte(8'h13);
        check("sync_pulse_end", 64'(bus.sync_err), 64'h0);
        for (int i = 0; i < 186; i++) send_byte(8'hFF);
        send_ts(8'h47, 13'h1386, 2'b01, 4'd9);
        send_ts(8'h47, 13'h1386, 2'b01, 4'd2);
        send_ts(8'h47, 13'h1386, 2'b01, 4'd11);
        send_ts(8'h47, 13'h1386, 2'b01, 4'd0);
        send_ts(8'h47, 13'h1386, 2'b01, 4'd13);
        gap(2);
        check("drop_cnt", 64'(cnt_of(0)), 64'h0);
        check("drop_flag", 64'(bus.cc_err_flag[0]), 64'h0);
        check("drop_strobes", 64'(strobe_cnt - base_s), 64'd1);
        check("drop_syncs", 64'(sync_cnt - base_y), 64'd1);

        // clr coincident with an error wins; history is also cleared.
        pulse_clr();
        packet(13'h1386, 2'b01, 4'd1);
        send_hdr();
        send_byte(8'h47);
        send_byte({3'b010, 5'h13});
        send_byte(8'h86);
        bus.clr = 1'b1;
        send_byte({4'b0001, 4'd7});
        bus.clr = 1'b0;
        gap(1);
        check("clr_win_flag", 64'(bus.cc_err_flag[0]), 64'h0);
        check("clr_win_cnt", 64'(cnt_of(0)), 64'h0);
        packet(13'h1386, 2'b01, 4'd8);
        packet(13'h1386, 2'b01, 4'd9);
        check("clr_hist_cnt", 64'(cnt_of(0)), 64'h0);

        // Saturation: 12 errors, then 3 to reach all-ones, then 2 more.
        pulse_clr();
        packet(13'h1386, 2'b01, 4'd0);
        for (int i = 1; i <= 12; i++) packet(13'h1386, 2'b01, 4'(2 * i));
        check("sat_pre_cnt", 64'(cnt_of(0)), 64'd12);
        for (int i = 13; i <= 15; i++) packet(13'h1386, 2'b01, 4'(2 * i));
        check("sat_cnt", 64'(cnt_of(0)), 64'd15);
        for (int i = 16; i <= 17; i++) packet(13'h1386, 2'b01, 4'(2 * i));
        check("sat_hold_cnt", 64'(cnt_of(0)), 64'd15);
        check("sat_flag", 64'(bus.cc_err_flag[0]), 64'h1);

        // Two slots on one PID; AFC=10 packets are not checked.
        bus.pid_cfg[25:13] = 13'h1386;
        bus.pid_en         = 4'b0011;
        gap(1);
        pulse_clr();
        packet(13'h1386, 2'b01, 4'd3);
        packet(13'h1386, 2'b10, 4'd9);
        packet(13'h1386, 2'b01, 4'd4);
        check("afc_flags", 64'(bus.cc_err_flag), 64'h0);
        check("afc_cnt0", 64'(cnt_of(0)), 64'h0);
        check("afc_cnt1", 64'(cnt_of(1)), 64'h0);
        packet(13'h1386, 2'b11, 4'd6);
        check("dual_flags", 64'(bus.cc_err_flag), 64'h3);
        check("dual_cnt0", 64'(cnt_of(0)), 64'h1);
        check("dual_cnt1", 64'(cnt_of(1)), 64'h1);

        // Disabling a slot drops its history but keeps flag and count.
        bus.pid_en = 4'b0010;
        gap(1);
        bus.pid_en = 4'b0011;
        gap(1);
        packet(13'h1386, 2'b01, 4'd0);
        check("en_hist_cnt0", 64'(cnt_of(0)), 64'h1);
        check("en_hist_flag0", 64'(bus.cc_err_flag[0]), 64'h1);
        check("en_hist_cnt1", 64'(cnt_of(1)), 64'h2);

        // PID 0x1FFF never matches.
        bus.pid_cfg[38:26] = 13'h1FFF;
        bus.pid_en         = 4'b0111;
        gap(1);
        packet(13'h1FFF, 2'b01, 4'd0);
        packet(13'h1FFF, 2'b01, 4'd5);
        check("null_flag2", 64'(bus.cc_err_flag[2]), 64'h0);
        check("null_cnt2", 64'(cnt_of(2)), 64'h0);

        // Reset mid-burst: tail of the burst is ignored.
        base_s = strobe_cnt;
        send_hdr();
        send_byte(8'h47);
        rst = 1'b1;
        send_byte({3'b010, 5'h13});
        rst = 1'b0;
        send_hdr();
        send_head(8'h47, 13'h1386, 2'b01, 4'd3);
        send_head(8'h47, 13'h1386, 2'b01, 4'd9);
        gap(2);
        check("rstmid_strobes", 64'(strobe_cnt - base_s), 64'd0);
        check("rstmid_flags", 64'(bus.cc_err_flag), 64'h0);
        check("rstmid_cnt", 64'(bus.cc_err_cnt), 64'h0);
        packet(13'h1386, 2'b01, 4'd3);
        check("rstmid_recover", 64'(strobe_cnt - base_s), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
